// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed image over UART (8N1), writes it into
// instruction memory word by word, then releases the core from reset.
module imem_uart_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        uart_rx,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_resetn,
   output logic        load_done,
   output logic        frame_err
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CAP  = 1 << ADDR_WIDTH;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERROR} ld_state_t;

   rx_state_t             rx_state, rx_next;
   ld_state_t             ld_state, ld_next;
   logic                  rx_meta, rx_sync;
   logic [CW-1:0]         clk_cnt;
   logic [2:0]            bit_idx;
   logic [7:0]            rx_byte;
   logic                  byte_valid, stop_err;
   logic                  bit_end, last_word;
   logic [7:0]            len_lo;
   logic [15:0]           len, len_in;
   logic [31:0]           word;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH:0]   word_idx;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
      end
   end

   assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rx_state <= RX_IDLE;
      else         rx_state <= rx_next;
   end

   // Start bit is re-checked mid-bit so a short low glitch never opens a frame
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_sync) rx_next = RX_START;
         RX_START: if (clk_cnt == CW'(HALF - 1)) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (bit_end && bit_idx == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (bit_end) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_cnt    <= '0;
         bit_idx    <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
         if (rx_state == RX_IDLE || rx_next != rx_state || bit_end)
            clk_cnt <= '0;
         else
            clk_cnt <= clk_cnt + 1'b1;
         if (rx_state == RX_IDLE)
            bit_idx <= '0;
         if (rx_state == RX_DATA && bit_end) begin
            rx_byte <= {rx_sync, rx_byte[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (rx_state == RX_STOP && bit_end) begin
            byte_valid <= rx_sync;
            stop_err   <= !rx_sync;
         end
      end
   end

   assign len_in    = {rx_byte, len_lo};
   assign last_word = (32'(word_idx) + 32'd1 == 32'(len));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ld_state <= LEN_LO;
      else         ld_state <= ld_next;
   end

   // Framing errors only matter while an image is still expected
   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         LEN_LO: if (byte_valid) ld_next = LEN_HI;
         LEN_HI: if (byte_valid) begin
            if (len_in == 16'd0)          ld_next = DONE;
            else if (32'(len_in) > CAP)   ld_next = ERROR;
            else                          ld_next = DATA;
         end
         DATA:    if (imem_we && last_word) ld_next = DONE;
         default: ld_next = ld_state;
      endcase
      if (stop_err && (ld_state == LEN_LO || ld_state == LEN_HI || ld_state == DATA))
         ld_next = ERROR;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         len_lo     <= '0;
         len        <= '0;
         word       <= '0;
         byte_cnt   <= '0;
         word_idx   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         load_done  <= 1'b0;
         cpu_resetn <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         imem_we    <= 1'b0;
         load_done  <= (ld_next == DONE);
         cpu_resetn <= (ld_next == DONE);
         frame_err  <= frame_err | (ld_next == ERROR);
         if (ld_state == LEN_LO && byte_valid) len_lo <= rx_byte;
         if (ld_state == LEN_HI && byte_valid) len <= len_in;
         if (ld_state == DATA && byte_valid) begin
            word     <= {rx_byte, word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
               imem_we    <= 1'b1;
               imem_wdata <= {rx_byte, word[31:8]};
               imem_addr  <= {{(30 - ADDR_WIDTH){1'b0}}, word_idx[ADDR_WIDTH-1:0], 2'b00};
            end
         end
         if (imem_we) word_idx <= word_idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: table of one-word images plus
// hand-written sequences for length, framing, glitch and reset corner cases.
module tb_imem_uart_loader;
   localparam int CPB = 4;
   localparam int AW  = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        uart_rx = 1'b1;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_resetn;
   logic        load_done;
   logic        frame_err;

   imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .resetn(resetn), .uart_rx(uart_rx),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_resetn(cpu_resetn), .load_done(load_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int last_we = -1;
   int done_cyc = -1;
   bit cpu_seen = 1'b0;
   logic [31:0] wr_addr [32];
   logic [31:0] wr_data [32];

   // Write/status monitor sampled on the falling edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!resetn) begin
         wr_cnt   <= 0;
         last_we  <= -1;
         done_cyc <= -1;
         cpu_seen <= 1'b0;
      end else begin
         if (imem_we) begin
            if (wr_cnt < 32) begin
               wr_addr[wr_cnt] <= imem_addr;
               wr_data[wr_cnt] <= imem_wdata;
            end
            wr_cnt  <= wr_cnt + 1;
            last_we <= cyc;
         end
         if (load_done && done_cyc < 0) done_cyc <= cyc;
         if (cpu_resetn) cpu_seen <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_bit(input logic v);
      repeat (CPB) begin
         @(negedge clk);
         uart_rx = v;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},    {31'd0, imem_we}, 32'd0);
      check({tag, "_addr"},  imem_addr, 32'd0);
      check({tag, "_wdata"}, imem_wdata, 32'd0);
      check({tag, "_cpu"},   {31'd0, cpu_resetn}, 32'd0);
      check({tag, "_done"},  {31'd0, load_done}, 32'd0);
      check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
   endtask

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [5];
   logic [31:0] w;

   initial begin
      vecs[0] = '{8'h13, 8'h05, 8'h50, 8'h00, 32'h0050_0513};
      vecs[1] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000};
      vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
      vecs[4] = '{8'h01, 8'h02, 8'h04, 8'h80, 32'h8004_0201};

      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Two-word image
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h0050_0513);
      check("two_mid_cnt", wr_cnt, 1);
      check("two_mid_done", {31'd0, load_done}, 32'd0);
      send_word(32'h0010_0593);
      check("two_cnt", wr_cnt, 2);
      check("two_addr0", wr_addr[0], 32'h0);
      check("two_data0", wr_data[0], 32'h0050_0513);
      check("two_addr1", wr_addr[1], 32'h4);
      check("two_data1", wr_data[1], 32'h0010_0593);
      check("two_done_timing", done_cyc, last_we + 1);
      check("two_cpu", {31'd0, cpu_resetn}, 32'd1);
      check("two_ferr", {31'd0, frame_err}, 32'd0);
      check("two_hold_addr", imem_addr, 32'h4);
      check("two_hold_data", imem_wdata, 32'h0010_0593);
      send_word(32'h1234_5678);
      check("done_ignores_cnt", wr_cnt, 2);
      check("done_sticky", {31'd0, load_done}, 32'd1);

      // Zero-length image
      do_reset();
      send_byte(8'h00);
      check("n0_hdr_done", {31'd0, load_done}, 32'd0);
      send_byte(8'h00);
      check("n0_cnt", wr_cnt, 0);
      check("n0_done", {31'd0, load_done}, 32'd1);
      check("n0_cpu", {31'd0, cpu_resetn}, 32'd1);

      // Oversize length
      do_reset();
      send_byte(8'h11); send_byte(8'h00);
      check("big_ferr", {31'd0, frame_err}, 32'd1);
      send_word(32'hA5A5_A5A5);
      repeat (1000) @(negedge clk);
      check("big_cnt", wr_cnt, 0);
      check("big_cpu_never", {31'd0, cpu_seen}, 32'd0);
      check("big_done", {31'd0, load_done}, 32'd0);

      // Bad stop bit during data, then recovery
      do_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAB, 1'b0);
      check("stop_ferr", {31'd0, frame_err}, 32'd1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      check("stop_cnt", wr_cnt, 0);
      check("stop_cpu", {31'd0, cpu_seen}, 32'd0);
      do_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'hCAFE_F00D);
      check("rec_cnt", wr_cnt, 1);
      check("rec_addr", wr_addr[0], 32'h0);
      check("rec_data", wr_data[0], 32'hCAFE_F00D);
      check("rec_done", {31'd0, load_done}, 32'd1);
      check("rec_ferr", {31'd0, frame_err}, 32'd0);

      // One-cycle glitch while idle
      do_reset();
      @(negedge clk); uart_rx = 1'b0;
      @(negedge clk); uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'hDEAD_BEEF);
      check("glitch_cnt", wr_cnt, 1);
      check("glitch_addr", wr_addr[0], 32'h0);
      check("glitch_data", wr_data[0], 32'hDEAD_BEEF);
      check("glitch_ferr", {31'd0, frame_err}, 32'd0);

      // Table of one-word images
      for (int v = 0; v < 5; v++) begin
         do_reset();
         send_byte(8'h01); send_byte(8'h00);
         send_byte(vecs[v].b0); send_byte(vecs[v].b1);
         send_byte(vecs[v].b2); send_byte(vecs[v].b3);
         check($sformatf("vec%0d_cnt", v), wr_cnt, 1);
         check($sformatf("vec%0d_addr", v), wr_addr[0], 32'h0);
         check($sformatf("vec%0d_data", v), wr_data[0], vecs[v].exp);
         check($sformatf("vec%0d_done", v), {31'd0, load_done}, 32'd1);
      end

      // Reset mid-word, then a full-capacity image
      do_reset();
      send_byte(8'h04); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("midrst");
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      send_byte(8'h10); send_byte(8'h00);
      for (int i = 0; i < 16; i++) begin
         w = {8'(16*i + 3), 8'(16*i + 2), 8'(16*i + 1), 8'(16*i)};
         send_word(w);
      end
      check("full_cnt", wr_cnt, 16);
      for (int i = 0; i < 16; i++) begin
         w = {8'(16*i + 3), 8'(16*i + 2), 8'(16*i + 1), 8'(16*i)};
         check($sformatf("full_addr%0d", i), wr_addr[i], 32'(i * 4));
         check($sformatf("full_data%0d", i), wr_data[i], w);
      end
      check("full_done_timing", done_cyc, last_we + 1);
      check("full_done", {31'd0, load_done}, 32'd1);
      check("full_cpu", {31'd0, cpu_resetn}, 32'd1);
      check("full_ferr", {31'd0, frame_err}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
